// File: rtl/reduce_accum.sv
// reduce_accum: element-wise reduction of reduce-packet payloads into an
// on-chip accumulator, with a pop-style readout once all contributions land.

// One accumulator slot update: the first contribution seeds the slot, later
// ones fold in according to the reduce op.
module reduce_lane (
    input  logic [1:0]  op,
    input  logic        first,
    input  logic [31:0] acc_old,
    input  logic [31:0] elem,
    output logic [31:0] acc_new
);
    // Combine rule; ops 1/2 compare as signed 32-bit values.
    always_comb begin
        acc_new = elem;
        if (!first) begin
            case (op)
                2'd0:    acc_new = acc_old + elem;
                2'd1:    acc_new = ($signed(elem) > $signed(acc_old)) ? elem : acc_old;
                2'd2:    acc_new = ($signed(elem) < $signed(acc_old)) ? elem : acc_old;
                default: acc_new = acc_old | elem;
            endcase
        end
    end
endmodule

module reduce_accum #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int MAX_ELEMS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    input  logic                  decode_done,
    input  logic                  reduce_pkt,
    input  logic [15:0]           op,
    input  logic [15:0]           count,
    input  logic [15:0]           num_contrib,
    input  logic                  res_rd,
    output logic                  res_valid,
    output logic [31:0]           res_data,
    output logic                  res_last,
    output logic                  pkt_accepted,
    output logic                  pkt_dropped,
    output logic [15:0]           contrib_cnt
);
    localparam int NUM_LANES = DATA_WIDTH/32;
    localparam int IW        = $clog2(MAX_ELEMS);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WAIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [15:0]   word_cnt;            // 0 = between packets
    logic          hdr_seen;            // reduce header decoded for this packet
    logic [15:0]   lat_op, lat_count;   // per-packet header capture
    logic [15:0]   first_op, first_count, nc_lat;  // reduction context
    logic          pkt_acc, pkt_rej;    // verdict taken at word 9
    logic [IW-1:0] rd_idx;
    logic [31:0]   acc [MAX_ELEMS];

    logic          in_pkt, sop, eop, pkt_word, is_w9, hdr_now, is_red;
    logic          fmt_ok, match_ok, ok, acc_now, rej_now, first;
    logic          commit, pop, last_pop;
    logic [15:0]   cur_word, eff_op, eff_count, count_use, nc_live, nc_use, new_cnt;
    logic [1:0]    op_use;
    logic [16:0]   base;

    logic [NUM_LANES-1:0][16:0] lane_idx;
    logic [NUM_LANES-1:0][31:0] lane_elem, lane_old, lane_new;
    logic [NUM_LANES-1:0]       lane_we;

    assign in_pkt   = (word_cnt != 16'd0);
    assign sop      = in_wr && !in_pkt && (in_ctrl == '0);
    assign eop      = in_wr && in_pkt && (in_ctrl != '0);
    assign pkt_word = in_wr && (in_pkt || (in_ctrl == '0));
    assign cur_word = in_pkt ? word_cnt + 16'd1 : 16'd1;
    assign is_w9    = pkt_word && (cur_word == 16'd9);

    // Header may land in the same cycle as word 9: prefer the live inputs then.
    assign hdr_now   = decode_done && reduce_pkt;
    assign is_red    = hdr_seen || hdr_now;
    assign eff_op    = hdr_now ? op : lat_op;
    assign eff_count = hdr_now ? count : lat_count;

    assign first    = (contrib_cnt == 16'd0);
    assign fmt_ok   = (eff_op < 16'd4) && (eff_count != 16'd0) && (eff_count <= 16'(MAX_ELEMS));
    assign match_ok = first || ((eff_op == first_op) && (eff_count == first_count));
    assign ok       = fmt_ok && match_ok && (state != S_DONE);
    assign acc_now  = pkt_acc || (is_w9 && is_red && ok);
    assign rej_now  = pkt_rej || (is_w9 && is_red && !ok);

    // Context registers are not yet loaded during word 9 of the first packet.
    assign op_use    = is_w9 ? eff_op[1:0] : first_op[1:0];
    assign count_use = is_w9 ? eff_count : first_count;
    assign nc_live   = (num_contrib == 16'd0) ? 16'd1 : num_contrib;
    assign nc_use    = (is_w9 && first) ? nc_live : nc_lat;

    assign commit   = eop && acc_now;
    assign new_cnt  = contrib_cnt + 16'd1;
    assign pop      = res_rd && (state == S_DONE);
    assign last_pop = pop && ({{(16-IW){1'b0}}, rd_idx} == first_count - 16'd1);

    // Payload word k carries elements 2k (upper half) and 2k+1 (lower half).
    assign base = {cur_word - 16'd9, 1'b0};

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            assign lane_idx[l]  = base + 17'(l);
            assign lane_elem[l] = in_data[DATA_WIDTH-1-32*l -: 32];
            assign lane_we[l]   = pkt_word && acc_now && (cur_word >= 16'd9) &&
                                  (lane_idx[l] < {1'b0, count_use});
            assign lane_old[l]  = acc[lane_idx[l][IW-1:0]];
            reduce_lane u_lane (
                .op      (op_use),
                .first   (first),
                .acc_old (lane_old[l]),
                .elem    (lane_elem[l]),
                .acc_new (lane_new[l])
            );
        end
    endgenerate

    // Accumulator: both elements of a payload word commit on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_we[i]) acc[lane_idx[i][IW-1:0]] <= lane_new[i];
    end

    // Word counter: 1 on packet start, clears after EOP, saturates on runaway.
    always_ff @(posedge clk) begin
        if (reset)
            word_cnt <= '0;
        else if (in_wr) begin
            if (!in_pkt)                    word_cnt <= (in_ctrl == '0) ? 16'd1 : 16'd0;
            else if (in_ctrl != '0)         word_cnt <= '0;
            else if (word_cnt != 16'hFFFF)  word_cnt <= word_cnt + 16'd1;
        end
    end

    // Header capture from the decoder, scoped to the current packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_seen  <= 1'b0;
            lat_op    <= '0;
            lat_count <= '0;
        end else begin
            if (hdr_now) begin
                lat_op    <= op;
                lat_count <= count;
            end
            if (eop || sop)   hdr_seen <= 1'b0;
            else if (hdr_now) hdr_seen <= 1'b1;
        end
    end

    // Accept/drop verdict held from word 9 through EOP.
    always_ff @(posedge clk) begin
        if (reset || eop) begin
            pkt_acc <= 1'b0;
            pkt_rej <= 1'b0;
        end else if (is_w9) begin
            pkt_acc <= acc_now;
            pkt_rej <= rej_now;
        end
    end

    // Reduction context sampled on the first accepted packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_op    <= '0;
            first_count <= '0;
            nc_lat      <= '0;
        end else if (is_w9 && acc_now && first) begin
            first_op    <= eff_op;
            first_count <= eff_count;
            nc_lat      <= nc_live;
        end
    end

    // Contribution count, read pointer and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            contrib_cnt  <= '0;
            rd_idx       <= '0;
            pkt_accepted <= 1'b0;
            pkt_dropped  <= 1'b0;
        end else begin
            pkt_accepted <= commit;
            pkt_dropped  <= eop && rej_now;
            if (last_pop) begin
                contrib_cnt <= '0;
                rd_idx      <= '0;
            end else begin
                if (commit) contrib_cnt <= new_cnt;
                if (pop)    rd_idx      <= rd_idx + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: commits decide WAIT vs DONE, last pop returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WAIT: begin
                if (commit)                state_nxt = (new_cnt == nc_use) ? S_DONE : S_WAIT;
                else if (is_w9 && acc_now) state_nxt = S_ACCUM;
            end
            S_ACCUM: if (commit)   state_nxt = (new_cnt == nc_use) ? S_DONE : S_WAIT;
            S_DONE:  if (last_pop) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Readout, forced to zero while no result is presented.
    always_comb begin
        res_valid = (state == S_DONE);
        res_data  = res_valid ? acc[rd_idx] : 32'd0;
        res_last  = res_valid && ({{(16-IW){1'b0}}, rd_idx} == first_count - 16'd1);
    end
endmodule

// File: tb/tb_reduce_accum.sv
// Bench for reduce_accum: directed scenarios plus randomized reductions,
// checked against a behavioural model of the reduction rules.
module tb_reduce_accum;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr, decode_done, reduce_pkt, res_rd;
    logic [15:0] op, count, num_contrib;
    logic        res_valid, res_last, pkt_accepted, pkt_dropped;
    logic [31:0] res_data;
    logic [15:0] contrib_cnt;

    always #5 clk = ~clk;

    reduce_accum dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .decode_done(decode_done), .reduce_pkt(reduce_pkt), .op(op), .count(count),
        .num_contrib(num_contrib), .res_rd(res_rd), .res_valid(res_valid),
        .res_data(res_data), .res_last(res_last), .pkt_accepted(pkt_accepted),
        .pkt_dropped(pkt_dropped), .contrib_cnt(contrib_cnt)
    );

    int tests = 0, fails = 0;
    int acc_seen = 0, drop_seen = 0, acc_exp = 0, drop_exp = 0;

    always @(negedge clk) begin
        if (pkt_accepted) acc_seen++;
        if (pkt_dropped)  drop_seen++;
    end

    // Reference state: what the reduction should hold after each packet.
    logic [31:0] m_acc [64];
    int          m_cnt = 0, m_op = 0, m_count = 0, m_nc = 1;
    bit          m_done = 1'b0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] combine(int o, logic [31:0] a, logic [31:0] e);
        case (o)
            0:       return a + e;
            1:       return ($signed(a) > $signed(e)) ? a : e;
            2:       return ($signed(a) < $signed(e)) ? a : e;
            default: return a | e;
        endcase
    endfunction

    function automatic void model_pkt(bit is_reduce, int o, int c, logic [31:0] el[$]);
        if (!is_reduce) return;
        if (o < 4 && c >= 1 && c <= 64 && !m_done && (m_cnt == 0 || (o == m_op && c == m_count))) begin
            if (m_cnt == 0) begin
                m_op = o; m_count = c;
                m_nc = (num_contrib == 0) ? 1 : int'(num_contrib);
                for (int i = 0; i < c; i++) m_acc[i] = el[i];
            end else
                for (int i = 0; i < c; i++) m_acc[i] = combine(o, m_acc[i], el[i]);
            m_cnt++;
            acc_exp++;
            if (m_cnt == m_nc) m_done = 1'b1;
        end else
            drop_exp++;
    endfunction

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic mk_q(input int n);
        int k;
        q.delete();
        k = (n >= 1 && n <= 64) ? n : 4;
        k += $urandom_range(0, 3);
        for (int i = 0; i < k; i++) q.push_back(rnd_elem());
    endtask

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
        in_data = d; in_ctrl = c; in_wr = 1'b1;
        @(posedge clk); #1;
        in_wr = 1'b0; decode_done = 1'b0;
        reduce_pkt = 1'($urandom); op = 16'($urandom); count = 16'($urandom);
    endtask

    task automatic maybe_gap();
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    // kind: 0 = no decode_done, 1 = decoded non-reduce, 2 = reduce packet.
    // early: decode_done in an idle cycle before word 9 instead of with it.
    task automatic send_pkt(input int kind, input int o, input int c, input logic [31:0] el[$], input bit early);
        int nw;
        logic [31:0] hi, lo;
        nw = (el.size() + 1) / 2;
        if (nw == 0) nw = 1;
        for (int w = 1; w <= 8; w++) begin
            drive_word({$urandom, $urandom}, 8'h00);
            if (w < 8) maybe_gap();
        end
        if (early) begin
            decode_done = (kind > 0); reduce_pkt = (kind == 2); op = 16'(o); count = 16'(c);
            @(posedge clk); #1;
            decode_done = 1'b0; op = 16'($urandom); count = 16'($urandom);
        end
        for (int w = 0; w < nw; w++) begin
            if (w == 0 && !early) begin
                decode_done = (kind > 0); reduce_pkt = (kind == 2); op = 16'(o); count = 16'(c);
            end
            hi = (2*w < el.size())     ? el[2*w]     : $urandom;
            lo = (2*w + 1 < el.size()) ? el[2*w + 1] : $urandom;
            drive_word({hi, lo}, (w == nw - 1) ? 8'hFF : 8'h00);
            if (w < nw - 1) maybe_gap();
        end
        model_pkt(kind == 2, o, c, el);
    endtask

    task automatic check_status(input string tag);
        @(posedge clk); #1;
        chk({tag, " acc_pulses"},  acc_seen,   acc_exp);
        chk({tag, " drop_pulses"}, drop_seen,  drop_exp);
        chk({tag, " contrib_cnt"}, contrib_cnt, m_cnt);
        chk({tag, " res_valid"},   res_valid,  m_done);
    endtask

    task automatic pop_all(input string tag);
        for (int i = 0; i < m_count; i++) begin
            chk({tag, " pop valid"}, res_valid, 1);
            chk({tag, " pop data"},  res_data,  m_acc[i]);
            chk({tag, " pop last"},  res_last,  (i == m_count - 1));
            res_rd = 1'b1;
            @(posedge clk); #1;
            res_rd = 1'b0;
        end
        m_cnt = 0; m_done = 1'b0;
        chk({tag, " valid after pops"}, res_valid,  0);
        chk({tag, " cnt after pops"},   contrib_cnt, 0);
    endtask

    int o, c, v, po, pc;

    initial begin
        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; decode_done = 1'b0;
        reduce_pkt = 1'b0; op = '0; count = '0; num_contrib = '0; res_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst res_valid", res_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst res_last", res_last, 0);
        chk("rst pkt_accepted", pkt_accepted, 0);
        chk("rst pkt_dropped", pkt_dropped, 0);
        chk("rst contrib_cnt", contrib_cnt, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Sum of three contributions.
        num_contrib = 3;
        q = {32'd1, 32'd2, 32'd3, 32'd4};       send_pkt(2, 0, 4, q, 1'b0);
        q = {32'd10, 32'd20, 32'd30, 32'd40};   send_pkt(2, 0, 4, q, 1'b1);
        q = {32'd100, 32'd200, 32'd300, 32'd400}; send_pkt(2, 0, 4, q, 1'b0);
        chk("sum accepted pulse", pkt_accepted, 1);
        chk("sum valid with pulse", res_valid, 1);
        chk("sum first result", res_data, 32'd111);
        check_status("sum");
        pop_all("sum");

        // Signed max, then wrapping add.
        num_contrib = 2;
        q = {32'hFFFF_FFFF, 32'd5}; send_pkt(2, 1, 2, q, 1'b0);
        q = {32'd3, 32'h8000_0000}; send_pkt(2, 1, 2, q, 1'b0);
        check_status("max");
        chk("max elem0", res_data, 32'd3);
        pop_all("max");
        q = {32'hFFFF_FFFF}; send_pkt(2, 0, 1, q, 1'b0);
        q = {32'd2};         send_pkt(2, 0, 1, q, 1'b1);
        check_status("wrap");
        chk("wrap result", res_data, 32'd1);
        pop_all("wrap");

        // Count mismatch on the second contribution is dropped.
        q = {32'd5, 32'd6, 32'd7, 32'd8}; send_pkt(2, 0, 4, q, 1'b0);
        q = {32'd9, 32'd9, 32'd9};        send_pkt(2, 0, 3, q, 1'b0);
        chk("mismatch drop pulse", pkt_dropped, 1);
        chk("mismatch no accept", pkt_accepted, 0);
        check_status("mismatch");
        q = {32'd1, 32'd1, 32'd1, 32'd1}; send_pkt(2, 0, 4, q, 1'b0);
        check_status("mismatch fix");
        pop_all("mismatch");

        // Non-reduce traffic and stray pops while waiting.
        q = {32'd4, 32'd4}; send_pkt(2, 3, 2, q, 1'b0);
        mk_q(2); send_pkt(0, 0, 2, q, 1'b0);
        mk_q(2); send_pkt(1, 0, 2, q, 1'b1);
        res_rd = 1'b1; @(posedge clk); #1; res_rd = 1'b0;
        check_status("nonreduce");
        q = {32'd1, 32'd2}; send_pkt(2, 3, 2, q, 1'b0);
        check_status("nonreduce fin");
        pop_all("nonreduce");

        // Packet during DONE is dropped; readout then restarts cleanly.
        num_contrib = 1;
        q = {32'd11, 32'd22, 32'd33, 32'd44}; send_pkt(2, 0, 4, q, 1'b0);
        mk_q(4); send_pkt(2, 0, 4, q, 1'b0);
        chk("done drop pulse", pkt_dropped, 1);
        check_status("done bp");
        pop_all("done bp");
        num_contrib = 2;
        mk_q(4); send_pkt(2, 0, 4, q, 1'b0);
        check_status("restart");
        mk_q(4); send_pkt(2, 0, 4, q, 1'b0);
        pop_all("restart");

        // Header field boundaries.
        num_contrib = 0;
        mk_q(2);  send_pkt(2, 4, 2, q, 1'b0);
        mk_q(0);  send_pkt(2, 0, 0, q, 1'b0);
        mk_q(65); send_pkt(2, 0, 65, q, 1'b1);
        check_status("bad hdr");
        mk_q(64); send_pkt(2, 3, 64, q, 1'b0);
        check_status("count64");
        pop_all("count64");

        // Reset in the middle of the second contribution's payload.
        num_contrib = 3;
        q = {32'd3, 32'd4}; send_pkt(2, 0, 2, q, 1'b0);
        for (int w = 1; w <= 8; w++) drive_word({$urandom, $urandom}, 8'h00);
        decode_done = 1'b1; reduce_pkt = 1'b1; op = 0; count = 4;
        drive_word({32'd50, 32'd60}, 8'h00);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid rst res_valid", res_valid, 0);
        chk("mid rst res_data", res_data, 0);
        chk("mid rst res_last", res_last, 0);
        chk("mid rst accepted", pkt_accepted, 0);
        chk("mid rst dropped", pkt_dropped, 0);
        chk("mid rst contrib_cnt", contrib_cnt, 0);
        reset = 1'b0;
        m_cnt = 0; m_done = 1'b0;
        drive_word({$urandom, $urandom}, 8'h00);
        drive_word({$urandom, $urandom}, 8'hFF);
        check_status("post rst tail");
        num_contrib = 1;
        q = {32'd7, 32'd8}; send_pkt(2, 0, 2, q, 1'b0);
        check_status("post rst");
        pop_all("post rst");

        // Randomized reductions with interleaved bad and foreign packets.
        for (int r = 0; r < 20; r++) begin
            num_contrib = 16'($urandom_range(0, 3));
            o = $urandom_range(0, 3);
            c = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(1, 12);
            for (int p = 0; p < 8 && !m_done; p++) begin
                v  = $urandom_range(0, 9);
                po = (m_cnt > 0) ? m_op : o;
                pc = (m_cnt > 0) ? m_count : c;
                if (v == 2) begin po = $urandom_range(0, 7); pc = $urandom_range(0, 70); end
                mk_q(pc);
                send_pkt((v == 0) ? 0 : ((v == 1) ? 1 : 2), po, pc, q, 1'($urandom));
                if (m_cnt > 0) num_contrib = 16'($urandom_range(0, 3));
            end
            for (int p = 0; p < 4 && !m_done; p++) begin
                po = (m_cnt > 0) ? m_op : o;
                pc = (m_cnt > 0) ? m_count : c;
                mk_q(pc);
                send_pkt(2, po, pc, q, 1'($urandom));
            end
            check_status("rnd");
            if ($urandom_range(0, 1) == 1) begin
                mk_q(m_count); send_pkt(2, m_op, m_count, q, 1'b0);
                check_status("rnd done drop");
            end
            pop_all("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
